// File: rtl/sf2_pkg.sv
// -----------------------------------------------------------------------------
// sf2_pkg: shared types and constants for the SimpleFixed2 issue controller.
//   sb_entry_t : one scoreboard slot {valid, destination address}
//   issue_t    : decoded instruction as held in the one-entry hold buffer
//   NOP_OP / NOP_FMT : encoding of the no-op, which never enters the scoreboard
//   DEPTH_DEFAULT    : number of SimpleFixed2 delay stages tracked
// -----------------------------------------------------------------------------
package sf2_pkg;

    localparam int unsigned DEPTH_DEFAULT = 4;

    localparam int unsigned OP_W   = 11;
    localparam int unsigned FMT_W  = 3;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned IMM_W  = 18;

    localparam logic [0:OP_W-1]  NOP_OP  = '0;
    localparam logic [FMT_W-1:0] NOP_FMT = '0;

    typedef struct packed {
        logic              valid;
        logic [0:ADDR_W-1] addr;
    } sb_entry_t;

    typedef struct packed {
        logic [0:OP_W-1]    op;
        logic [FMT_W-1:0]   format;
        logic [0:ADDR_W-1]  rt_addr;
        logic [0:ADDR_W-1]  ra_addr;
        logic [0:ADDR_W-1]  rb_addr;
        logic               ra_used;
        logic               rb_used;
        logic               reg_write;
        logic [0:IMM_W-1]   imm;
    } issue_t;

    // True for the architectural no-op encoding.
    function automatic logic is_nop(input issue_t instr);
        return (instr.format == NOP_FMT) && (instr.op == NOP_OP);
    endfunction

endpackage

// File: rtl/sf2_scoreboard.sv
// -----------------------------------------------------------------------------
// sf2_scoreboard: shadow copy of the SimpleFixed2 in-flight destinations.
// sb[0] mirrors the issue register, sb[j] mirrors rt_delay[j-1]; the whole
// array shifts every cycle. Each used source is compared against every valid
// entry and classified as a hazard (must stall) or a forwardable match.
//
// Build option: SF2_FWD_EN moves the two oldest entries (sb[DEPTH-1..DEPTH])
// out of the hazard range and into the forwarding range. Without it every
// entry is a hazard and fwd_*_c stay 0.
//
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   push_valid/addr : new sb[0] contents (valid only for a real register write)
//   flush           : branch squash; sb[1] loads empty instead of sb[0]
//   ra_*/rb_*       : held instruction's source addresses and use flags
//   hazard_r*_c     : source matches an entry in the hazard range
//   fwd_r*_c        : source matches an entry in the forwarding range
// -----------------------------------------------------------------------------
module sf2_scoreboard
    import sf2_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_valid,
    input  logic [0:ADDR_W-1] push_addr,
    input  logic              flush,
    input  logic [0:ADDR_W-1] ra_addr,
    input  logic              ra_used,
    input  logic [0:ADDR_W-1] rb_addr,
    input  logic              rb_used,
    output logic              hazard_ra_c,
    output logic              hazard_rb_c,
    output logic              fwd_ra_c,
    output logic              fwd_rb_c
);

`ifdef SF2_FWD_EN
    localparam int unsigned HAZ_LAST = DEPTH - 2;
`else
    localparam int unsigned HAZ_LAST = DEPTH;
`endif

    sb_entry_t sb_q [DEPTH+1];
    sb_entry_t sb_d [DEPTH+1];

    // Shift: new entry at sb[0], squash the stage the pipe is sampling on flush.
    always_comb begin
        for (int unsigned j = 0; j <= DEPTH; j++) begin
            sb_d[j] = '0;
        end
        sb_d[0].valid = push_valid;
        sb_d[0].addr  = push_addr;
        sb_d[1]       = flush ? sb_entry_t'('0) : sb_q[0];
        for (int unsigned j = 2; j <= DEPTH; j++) begin
            sb_d[j] = sb_q[j-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned j = 0; j <= DEPTH; j++) begin
                sb_q[j] <= '0;
            end
        end else begin
            sb_q <= sb_d;
        end
    end

    // Per-source match, split into hazard and forwarding ranges.
    always_comb begin
        logic m_ra;
        logic m_rb;
        hazard_ra_c = 1'b0;
        hazard_rb_c = 1'b0;
        fwd_ra_c    = 1'b0;
        fwd_rb_c    = 1'b0;
        m_ra        = 1'b0;
        m_rb        = 1'b0;
        for (int unsigned j = 0; j <= DEPTH; j++) begin
            m_ra = ra_used && sb_q[j].valid && (sb_q[j].addr == ra_addr);
            m_rb = rb_used && sb_q[j].valid && (sb_q[j].addr == rb_addr);
            if (j <= HAZ_LAST) begin
                hazard_ra_c = hazard_ra_c | m_ra;
                hazard_rb_c = hazard_rb_c | m_rb;
            end else begin
                fwd_ra_c = fwd_ra_c | m_ra;
                fwd_rb_c = fwd_rb_c | m_rb;
            end
        end
    end

endmodule

// File: rtl/sf2_issue_ctrl.sv
// -----------------------------------------------------------------------------
// sf2_issue_ctrl: issue controller for the SimpleFixed2 (shift/rotate) pipe.
// Takes decoded instructions over a valid/ready handshake into a one-entry
// hold buffer, stalls on RAW hazards against a shadow scoreboard, and drives
// the pipe's RF/FWD-stage inputs from registers. Branch flushes squash both
// the held instruction and the scoreboard stage being sampled.
//
// Build option: SF2_FWD_EN enables bypass of the two oldest pipe stages
// (fwd_ra/fwd_rb registered with the issue); otherwise fwd_* read 0.
//
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   in_valid / in_ready  : decode handshake (in_ready is combinational)
//   in_*                 : decoded instruction fields
//   branch_taken         : flush request
//   iss_valid, iss_*     : registered issue to SimpleFixed2
//   fwd_ra, fwd_rb       : registered bypass selects for the issued instruction
//   stall_cnt            : saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module sf2_issue_ctrl
    import sf2_pkg::*;
#(
    parameter int unsigned DEPTH       = DEPTH_DEFAULT,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:10]            in_op,
    input  logic [2:0]             in_format,
    input  logic [0:6]             in_rt_addr,
    input  logic [0:6]             in_ra_addr,
    input  logic [0:6]             in_rb_addr,
    input  logic                   in_ra_used,
    input  logic                   in_rb_used,
    input  logic                   in_reg_write,
    input  logic [0:17]            in_imm,
    input  logic                   branch_taken,
    output logic                   iss_valid,
    output logic [0:10]            iss_op,
    output logic [2:0]             iss_format,
    output logic [0:6]             iss_rt_addr,
    output logic                   iss_reg_write,
    output logic [0:17]            iss_imm,
    output logic                   fwd_ra,
    output logic                   fwd_rb,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]             state_q, state_d;
    issue_t                 hold_q, hold_d;
    issue_t                 in_instr;

    logic                   iss_valid_q, iss_valid_d;
    logic [0:OP_W-1]        iss_op_q, iss_op_d;
    logic [FMT_W-1:0]       iss_format_q, iss_format_d;
    logic [0:ADDR_W-1]      iss_rt_addr_q, iss_rt_addr_d;
    logic                   iss_reg_write_q, iss_reg_write_d;
    logic [0:IMM_W-1]       iss_imm_q, iss_imm_d;
    logic                   fwd_ra_q, fwd_ra_d;
    logic                   fwd_rb_q, fwd_rb_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic hold_valid_c;
    logic hazard_ra_c, hazard_rb_c;
    logic sb_fwd_ra_c, sb_fwd_rb_c;
    logic hazard_c;
    logic issue_now_c;
    logic xfer_c;
    logic push_valid_c;

    assign in_instr = '{op:        in_op,
                        format:    in_format,
                        rt_addr:   in_rt_addr,
                        ra_addr:   in_ra_addr,
                        rb_addr:   in_rb_addr,
                        ra_used:   in_ra_used,
                        rb_used:   in_rb_used,
                        reg_write: in_reg_write,
                        imm:       in_imm};

    assign hold_valid_c = (state_q == ST_HOLD);
    assign hazard_c     = hold_valid_c && (hazard_ra_c || hazard_rb_c);
    assign issue_now_c  = hold_valid_c && !hazard_c && !branch_taken;
    // The buffer frees up in the same cycle it issues; a flush blocks intake.
    assign in_ready     = (!hold_valid_c || issue_now_c) && !branch_taken;
    assign xfer_c       = in_valid && in_ready;
    assign push_valid_c = issue_now_c && hold_q.reg_write && !is_nop(hold_q);

    sf2_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .push_valid  (push_valid_c),
        .push_addr   (hold_q.rt_addr),
        .flush       (branch_taken),
        .ra_addr     (hold_q.ra_addr),
        .ra_used     (hold_q.ra_used),
        .rb_addr     (hold_q.rb_addr),
        .rb_used     (hold_q.rb_used),
        .hazard_ra_c (hazard_ra_c),
        .hazard_rb_c (hazard_rb_c),
        .fwd_ra_c    (sb_fwd_ra_c),
        .fwd_rb_c    (sb_fwd_rb_c)
    );

    // Next state, hold buffer, issue registers and stall counter.
    always_comb begin
        state_d         = state_q;
        hold_d          = hold_q;
        iss_valid_d     = 1'b0;
        iss_op_d        = '0;
        iss_format_d    = '0;
        iss_rt_addr_d   = '0;
        iss_reg_write_d = 1'b0;
        iss_imm_d       = '0;
        fwd_ra_d        = 1'b0;
        fwd_rb_d        = 1'b0;
        stall_cnt_d     = stall_cnt_q;

        case (state_q)
            ST_EMPTY: begin
                if (xfer_c) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    state_d = ST_EMPTY;
                end else if (issue_now_c && !xfer_c) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (xfer_c) begin
            hold_d = in_instr;
        end

        if (issue_now_c) begin
            iss_valid_d     = 1'b1;
            iss_op_d        = hold_q.op;
            iss_format_d    = hold_q.format;
            iss_rt_addr_d   = hold_q.rt_addr;
            iss_reg_write_d = hold_q.reg_write;
            iss_imm_d       = hold_q.imm;
            fwd_ra_d        = sb_fwd_ra_c;
            fwd_rb_d        = sb_fwd_rb_c;
        end

        if (hazard_c && !branch_taken && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_EMPTY;
            hold_q          <= '0;
            iss_valid_q     <= 1'b0;
            iss_op_q        <= '0;
            iss_format_q    <= '0;
            iss_rt_addr_q   <= '0;
            iss_reg_write_q <= 1'b0;
            iss_imm_q       <= '0;
            fwd_ra_q        <= 1'b0;
            fwd_rb_q        <= 1'b0;
            stall_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            iss_valid_q     <= iss_valid_d;
            iss_op_q        <= iss_op_d;
            iss_format_q    <= iss_format_d;
            iss_rt_addr_q   <= iss_rt_addr_d;
            iss_reg_write_q <= iss_reg_write_d;
            iss_imm_q       <= iss_imm_d;
            fwd_ra_q        <= fwd_ra_d;
            fwd_rb_q        <= fwd_rb_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign iss_valid     = iss_valid_q;
    assign iss_op        = iss_op_q;
    assign iss_format    = iss_format_q;
    assign iss_rt_addr   = iss_rt_addr_q;
    assign iss_reg_write = iss_reg_write_q;
    assign iss_imm       = iss_imm_q;
    assign fwd_ra        = fwd_ra_q;
    assign fwd_rb        = fwd_rb_q;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: doc/sf2_issue_ctrl.md
# sf2_issue_ctrl

Issue controller for the SimpleFixed2 (shift/rotate) pipe. Accepts decoded instructions from decode through a valid/ready handshake and holds them in a one-entry buffer. A shadow scoreboard of the pipe's in-flight destinations detects RAW hazards; the block stalls on a hazard and otherwise drives the pipe's RF/FWD-stage inputs from registers. It sits between decode and SimpleFixed2 and also applies branch flushes to both the held instruction and the scoreboard.

## Interface
Parameters:
- DEPTH, 4: SimpleFixed2 delay stages tracked (rt_delay[0..3]).
- STALL_CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; all state clears while low.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  block accepts the instruction this cycle.
- in_op  in  11  opcode [0:10].
- in_format  in  3  format [2:0].
- in_rt_addr, in_ra_addr, in_rb_addr  in  7 each  register addresses [0:6].
- in_ra_used, in_rb_used  in  1 each  source is actually read.
- in_reg_write  in  1  instruction writes rt.
- in_imm  in  18  immediate [0:17].
- branch_taken  in  1  flush request.
- iss_valid  out  1  issue-register contents are a live instruction.
- iss_op, iss_format, iss_rt_addr, iss_reg_write, iss_imm  out  11/3/7/1/18  registered copies sent to SimpleFixed2.
- fwd_ra, fwd_rb  out  1 each  bypass select for the issued instruction (forwarding builds only; tied to 0 otherwise).
- stall_cnt  out  STALL_CNT_W  saturating count of hazard-stall cycles.

## Operation
- FSM has two states.
  - EMPTY: hold buffer invalid.
  - HOLD: hold buffer valid.
- Handshake: in_ready = !hold_valid || issue_now. A transfer occurs when in_valid && in_ready. It loads the hold buffer at the next edge.
- Scoreboard: sb[0..DEPTH] of {valid, rt_addr}.
  - sb[0] mirrors the issue register; sb[j] mirrors rt_delay[j-1].
  - The scoreboard shifts every cycle.
  - sb[0] loads {issue_now && held reg_write && !nop, held rt_addr}.
- nop is format==0 && op==0. It issues normally but never creates a scoreboard entry.
- Hazard: a held source is used and its address equals the rt_addr of a valid entry in the compared range. The compared range is sb[0..DEPTH].
- issue_now = HOLD && !hazard && !branch_taken.
  - When issue_now is set, the iss_* registers load the held fields and iss_valid becomes 1.
  - When issue_now is clear, all iss_* outputs go to 0.
- stall_cnt increments in every cycle with HOLD && hazard && !branch_taken. It saturates at all-ones.
- branch_taken, on the cycle it is asserted:
  - hold_valid is cleared.
  - The input transfer is ignored; in_ready is 0.
  - The iss_* registers load 0.
  - sb[1] loads 0 instead of sb[0], because the pipe squashes the instruction it is sampling.
- reset low clears:
  - hold_valid, all sb entries, every iss_* output, fwd_ra/fwd_rb and stall_cnt to 0;
  - the FSM to EMPTY.
  Reset low while an instruction is held drops that instruction.

## Timing
- Accept at edge E. The hold buffer is valid in cycle E+1. With no hazard, the instruction appears on iss_* in cycle E+2.
- Throughput for independent instructions: one issue per cycle.
- Dependent pair without forwarding: producer on iss in cycle k, consumer on iss in cycle k+6 (5 stall cycles).

## Configuration
- Macro SF2_FWD_EN.
- Defined:
  - sb[DEPTH-1] and sb[DEPTH] are excluded from the hazard compare.
  - fwd_ra/fwd_rb are registered alongside the issue. Each is set when its used source matches a valid entry in sb[DEPTH-1..DEPTH].
  - Dependent pair: consumer on iss in cycle k+4.
- Undefined: the full compare range is used and fwd_ra/fwd_rb are tied to 0.

## Structure
- Package sf2_pkg holds:
  - sb_entry_t {logic valid; logic [0:6] addr};
  - issue_t, the held instruction struct;
  - the NOP_OP and NOP_FMT constants;
  - the DEPTH default.
- One sub-module, sf2_scoreboard. It holds the shift register and the per-source match logic. It returns hazard_ra, hazard_rb, fwd_ra and fwd_rb.

## Test plan
- Reset low mid-HOLD → all outputs 0, in_ready=1 after release, held instruction never issues.
- 4 independent shl instructions (rt=10..13, sources 1,2) back-to-back → iss_valid high 4 consecutive cycles, stall_cnt=0.
- shl rt=5 then rot ra=5, without SF2_FWD_EN → 5 stall cycles, stall_cnt=5, rot on iss at k+6.
- Same pair with SF2_FWD_EN → rot on iss at k+4 with fwd_ra=1 and fwd_rb=0.
- branch_taken while rot is held and shl rt=5 is on iss → neither rot nor the scoreboard entry survives. A following instruction reading r5 issues with no stall.
- nop followed by rothi ra=0 → no stall, because the nop does not enter the scoreboard.
